bird_motion_ctrl: RTL
=====================

// Module: bird_motion_ctrl
// PURPOSE
//  Frame-paced game controller. It replaces the ad-hoc key-press always block in the top level.
//  Consumes PS2 space-key events (press/release codes from PS2_Interface) and acks them.
//  Runs an IDLE/PLAY/OVER state machine. Applies gravity/flap physics once per VGA frame.
//  Drives bird_y and score into vga_controller (iBirdY/iScore) and the debug LEDs.
// PARAMETERS
//  Y_START      228   bird_y loaded on reset and on every new game
//  Y_MAX        456   lowest legal bird_y (screen 480 minus sprite); reaching it ends the game
//  GRAVITY      1     added to velocity each PLAY frame (unsigned)
//  FLAP_VEL     -8    velocity loaded on a flap (signed, 6-bit)
//  VEL_MAX      10    downward velocity ceiling (terminal velocity)
//  SCORE_FRAMES 60    PLAY frames survived per score increment
// PORTS
//  clock       in   1   system clock, all logic on posedge
//  resetn      in   1   asynchronous active-low reset
//  key_event   in   2   0=none, 1=space pressed, 2=space released, 3=ignored
//  key_ack     out  1   one-cycle consume strobe back to PS2_Interface
//  frame_tick  in   1   one-cycle pulse per VGA frame, synchronous to clock
//  bird_y      out  10  bird top row in pixels, 0..Y_MAX
//  score       out  16  frames-survived score, saturating
//  game_state  out  2   0=IDLE, 1=PLAY, 2=OVER (3 unused, never entered)
//  leds        out  8   {game_state, 5'b0, key_held}
// BEHAVIOUR
//  Reset (resetn=0, async), all outputs/regs cleared:
//   - state=IDLE, bird_y=Y_START, vel=0, score=0, frame_cnt=0
//   - flap_pending=0, key_held=0, key_ack=0
//  Key handshake: if key_event!=0 && key_ack==0, key_ack=1 next cycle, exactly one cycle.
//   - While key_ack=1, key_event is ignored. Code 3 is acked and discarded.
//   - Press sets key_held=1; release clears it.
//  Press effects by state:
//   - IDLE: go to PLAY; bird_y=Y_START, vel=FLAP_VEL, score=0, frame_cnt=0.
//   - PLAY: set flap_pending.
//   - OVER: go to IDLE; bird_y=Y_START, vel=0. score is held for display until the next game.
//  frame_tick in IDLE/OVER: no effect.
//  frame_tick in PLAY, with registered results visible the cycle after the tick:
//   - vel_n = flap_pending ? FLAP_VEL : min(vel+GRAVITY, VEL_MAX); flap_pending clears.
//   - y_n = bird_y + vel_n, computed as signed 12-bit.
//   - y_n <= 0: bird_y=0, state=OVER.
//   - y_n >= Y_MAX: bird_y=Y_MAX, state=OVER.
//   - Otherwise: bird_y=y_n[9:0].
//   - frame_cnt increments. When it reaches SCORE_FRAMES-1 it wraps to 0 and score increments.
//     score saturates at 16'hFFFF.
//   - The frame that causes OVER does not advance score or frame_cnt.
//  Simultaneous events:
//   - Press and frame_tick in the same cycle in PLAY: the flap applies on that tick.
//   - Press and tick in the same cycle in IDLE: the IDLE->PLAY load wins and the tick is ignored.
//  Velocity register: signed 6-bit, always within FLAP_VEL..VEL_MAX.
//  Mid-game reset: asserting resetn=0 at any time returns immediately to the reset values.
// TESTING
//  1. Reset, no keys, 10 ticks -> state=IDLE, bird_y=228, score=0, key_ack never high.
//  2. Press in IDLE -> 1-cycle key_ack, state=PLAY. Next tick: bird_y=220 (228-8), then 213 after the following tick.
//  3. Play with no flaps from Y_START -> vel reaches 10 and stays there.
//     bird_y clamps to 456 and state=OVER; further ticks leave bird_y=456.
//  4. Flap on every tick from bird_y=10 -> bird_y=2, then next tick y_n<0.
//     bird_y=0, state=OVER. Press -> IDLE, bird_y=228, score held.
//  5. Survive 120 ticks by flapping periodically -> score=2. Press coincident with a tick -> flap applies on that tick.
//  6. Assert resetn=0 mid-PLAY with key_event=1 held -> all outputs return to reset values at once.
//     After release, a single ack is issued.

Source files
------------

// File: rtl/bird_motion_ctrl.sv
// Frame-paced flappy-bird controller: PS2 space-key handshake, IDLE/PLAY/OVER FSM,
// and once-per-frame gravity/flap physics driving bird_y and a survival score.
module bird_motion_ctrl #(
    parameter int Y_START      = 228,
    parameter int Y_MAX        = 456,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = -8,
    parameter int VEL_MAX      = 10,
    parameter int SCORE_FRAMES = 60
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  key_event,
    output logic        key_ack,
    input  logic        frame_tick,
    output logic [9:0]  bird_y,
    output logic [15:0] score,
    output logic [1:0]  game_state,
    output logic [7:0]  leds
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam int FC_W = $clog2(SCORE_FRAMES);
    localparam logic signed [5:0]  FLAP_V  = 6'(FLAP_VEL);
    localparam logic signed [6:0]  VMAX7   = 7'(VEL_MAX);
    localparam logic signed [6:0]  GRAV7   = 7'(GRAVITY);
    localparam logic signed [11:0] YMAX12  = 12'(Y_MAX);
    localparam logic [9:0]         YSTART  = 10'(Y_START);
    localparam logic [9:0]         YMAX10  = 10'(Y_MAX);
    localparam logic [FC_W-1:0]    FC_LAST = FC_W'(SCORE_FRAMES - 1);

    logic [1:0]        state_q, state_d;
    logic [9:0]        y_q, y_d;
    logic signed [5:0] vel_q, vel_d;
    logic [15:0]       score_q, score_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              pend_q, pend_d;
    logic              held_q, held_d;
    logic              ack_q, ack_d;

    logic              accept, press, release_k;
    logic signed [6:0] vel_sum;
    logic signed [5:0] vel_grav, vel_n;
    logic signed [11:0] y_n;

    // A key code is consumed only when no ack is outstanding.
    assign accept    = (key_event != 2'd0) && !ack_q;
    assign press     = accept && (key_event == 2'd1);
    assign release_k = accept && (key_event == 2'd2);

    assign vel_sum  = {vel_q[5], vel_q} + GRAV7;
    assign vel_grav = (vel_sum > VMAX7) ? VMAX7[5:0] : vel_sum[5:0];
    assign vel_n    = (pend_q || press) ? FLAP_V : vel_grav;
    assign y_n      = $signed({2'b00, y_q}) + {{6{vel_n[5]}}, vel_n};

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        score_d = score_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        held_d  = held_q;
        ack_d   = accept;
        if (press)
            held_d = 1'b1;
        else if (release_k)
            held_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The starting flap is queued so the first PLAY frame rises by FLAP_VEL.
                if (press) begin
                    state_d = S_PLAY;
                    y_d     = YSTART;
                    vel_d   = FLAP_V;
                    pend_d  = 1'b1;
                    score_d = 16'd0;
                    fcnt_d  = '0;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    vel_d  = vel_n;
                    pend_d = 1'b0;
                    if (y_n <= 12'sd0) begin
                        y_d     = 10'd0;
                        state_d = S_OVER;
                    end else if (y_n >= YMAX12) begin
                        y_d     = YMAX10;
                        state_d = S_OVER;
                    end else begin
                        y_d = y_n[9:0];
                        if (fcnt_q == FC_LAST) begin
                            fcnt_d = '0;
                            if (score_q != 16'hFFFF)
                                score_d = score_q + 16'd1;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end else if (press) begin
                    pend_d = 1'b1;
                end
            end
            S_OVER: begin
                if (press) begin
                    state_d = S_IDLE;
                    y_d     = YSTART;
                    vel_d   = 6'sd0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            y_q     <= YSTART;
            vel_q   <= 6'sd0;
            score_q <= 16'd0;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
            held_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            score_q <= score_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
            ack_q   <= ack_d;
        end
    end

    assign key_ack    = ack_q;
    assign bird_y     = y_q;
    assign score      = score_q;
    assign game_state = state_q;
    assign leds       = {state_q, 5'b00000, held_q};
endmodule
